// File: rtl/ps2_pkg.sv
// Shared PS/2 host-transmit definitions: FSM states, default timing and common command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StStart,
        StData,
        StParity,
        StStop,
        StAck,
        StDone
    } ps2_tx_state_e;

    localparam int unsigned DefaultClkHz          = 50_000_000;
    localparam int unsigned DefaultInhibitUs      = 100;
    localparam int unsigned DefaultStartTimeoutUs = 15_000;
    localparam int unsigned DefaultXferTimeoutUs  = 2_000;

    localparam logic [7:0] CmdSetLeds = 8'hED;
    localparam logic [7:0] CmdEnable  = 8'hF4;
    localparam logic [7:0] CmdReset   = 8'hFF;

    // 64-bit product: microseconds times a 50 MHz clock overflows 32 bits.
    function automatic int unsigned us_to_cycles(input int unsigned us,
                                                 input int unsigned clk_hz);
        logic [63:0] prod;
        prod = 64'(us) * 64'(clk_hz);
        return 32'(prod / 64'd1_000_000);
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus clock falling-edge detect.
module ps2_line_sync (
    input  logic clock,
    input  logic reset,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic clk_sync_o,
    output logic dat_sync_o,
    output logic clk_fall_o
);
    logic [1:0] clk_meta_q;
    logic [1:0] dat_meta_q;
    logic       clk_old_q;

    // Preset to the idle-high bus level so leaving reset never looks like an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_meta_q <= 2'b11;
            dat_meta_q <= 2'b11;
            clk_old_q  <= 1'b1;
        end else begin
            clk_meta_q <= {clk_meta_q[0], ps2_clk_i};
            dat_meta_q <= {dat_meta_q[0], ps2_dat_i};
            clk_old_q  <= clk_meta_q[1];
        end
    end

    assign clk_sync_o = clk_meta_q[1];
    assign dat_sync_o = dat_meta_q[1];
    assign clk_fall_o = clk_old_q & ~clk_meta_q[1];

endmodule

// File: rtl/ps2_command_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, then shifts a byte out on device clocks.
// Define PS2_TX_ACK_CHECK_EN to treat a missing device acknowledge as an error.
module ps2_command_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ           = DefaultClkHz,
    parameter int unsigned INHIBIT_US       = DefaultInhibitUs,
    parameter int unsigned START_TIMEOUT_US = DefaultStartTimeoutUs,
    parameter int unsigned XFER_TIMEOUT_US  = DefaultXferTimeoutUs
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] the_command,
    input  logic       send_command,
    inout  wire        ps2_clk,
    inout  wire        ps2_dat,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_communication_timed_out
);
    localparam int unsigned InhibitCycles = us_to_cycles(INHIBIT_US, CLK_HZ);
    localparam int unsigned StartCycles   = us_to_cycles(START_TIMEOUT_US, CLK_HZ);
    localparam int unsigned XferCycles    = us_to_cycles(XFER_TIMEOUT_US, CLK_HZ);

    localparam int unsigned InhW   = (InhibitCycles > 1) ? $clog2(InhibitCycles) : 1;
    localparam int unsigned StartW = (StartCycles > 1) ? $clog2(StartCycles) : 1;
    localparam int unsigned XferW  = (XferCycles > 1) ? $clog2(XferCycles) : 1;

    localparam logic [InhW-1:0]   InhLast   = InhW'(InhibitCycles - 1);
    localparam logic [InhW-1:0]   InhDatLow = InhW'(InhibitCycles - 2);
    localparam logic [StartW-1:0] StartLast = StartW'(StartCycles - 1);
    localparam logic [XferW-1:0]  XferLast  = XferW'(XferCycles - 1);

    ps2_tx_state_e     state_q;
    logic [7:0]        cmd_q;
    logic [2:0]        bit_cnt_q;
    logic [InhW-1:0]   inh_cnt_q;
    logic [StartW-1:0] start_cnt_q;
    logic [XferW-1:0]  xfer_cnt_q;
    logic              clk_low_q, dat_low_q;
    logic              busy_q, sent_q, err_q;

    logic clk_sync, dat_sync, clk_fall;
    logic in_xfer;

    ps2_line_sync u_line_sync (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk_i  (ps2_clk),
        .ps2_dat_i  (ps2_dat),
        .clk_sync_o (clk_sync),
        .dat_sync_o (dat_sync),
        .clk_fall_o (clk_fall)
    );

    assign in_xfer = state_q inside {StData, StParity, StStop, StAck, StDone};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            cmd_q       <= '0;
            bit_cnt_q   <= '0;
            inh_cnt_q   <= '0;
            start_cnt_q <= '0;
            xfer_cnt_q  <= '0;
            clk_low_q   <= 1'b0;
            dat_low_q   <= 1'b0;
            busy_q      <= 1'b0;
            sent_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sent_q <= 1'b0;
            err_q  <= 1'b0;
            if (in_xfer) begin
                xfer_cnt_q <= (xfer_cnt_q == XferLast) ? xfer_cnt_q : xfer_cnt_q + 1'b1;
            end
            if (in_xfer && xfer_cnt_q == XferLast) begin
                clk_low_q <= 1'b0;
                dat_low_q <= 1'b0;
                err_q     <= 1'b1;
                busy_q    <= 1'b0;
                state_q   <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        clk_low_q <= 1'b0;
                        dat_low_q <= 1'b0;
                        if (send_command) begin
                            cmd_q     <= the_command;
                            bit_cnt_q <= '0;
                            inh_cnt_q <= '0;
                            clk_low_q <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= StInhibit;
                        end
                    end
                    StInhibit: begin
                        inh_cnt_q <= (inh_cnt_q == InhLast) ? inh_cnt_q : inh_cnt_q + 1'b1;
                        if (inh_cnt_q == InhDatLow) begin
                            dat_low_q <= 1'b1;
                        end
                        // Releasing the clock with data held low is the request-to-send.
                        if (inh_cnt_q == InhLast) begin
                            clk_low_q   <= 1'b0;
                            start_cnt_q <= '0;
                            state_q     <= StStart;
                        end
                    end
                    StStart: begin
                        if (clk_fall) begin
                            dat_low_q  <= ~cmd_q[0];
                            xfer_cnt_q <= '0;
                            state_q    <= StData;
                        end else if (start_cnt_q == StartLast) begin
                            dat_low_q <= 1'b0;
                            err_q     <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= StIdle;
                        end else begin
                            start_cnt_q <= start_cnt_q + 1'b1;
                        end
                    end
                    StData: begin
                        if (clk_fall) begin
                            if (bit_cnt_q == 3'd7) begin
                                // Odd parity bit is ~^cmd; the line is pulled low when it is 0.
                                dat_low_q <= ^cmd_q;
                                state_q   <= StParity;
                            end else begin
                                dat_low_q <= ~cmd_q[bit_cnt_q + 3'd1];
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                    end
                    StParity: begin
                        if (clk_fall) begin
                            dat_low_q <= 1'b0;
                            state_q   <= StStop;
                        end
                    end
                    StStop: begin
                        if (clk_fall) begin
                            state_q <= StAck;
                        end
                    end
                    StAck: begin
`ifdef PS2_TX_ACK_CHECK_EN
                        if (dat_sync) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            state_q <= StDone;
                        end
`else
                        state_q <= StDone;
`endif
                    end
                    StDone: begin
                        if (clk_sync && dat_sync) begin
                            sent_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                endcase
            end
        end
    end

    assign ps2_clk = clk_low_q ? 1'b0 : 1'bz;
    assign ps2_dat = dat_low_q ? 1'b0 : 1'bz;

    assign busy                          = busy_q;
    assign command_was_sent              = sent_q;
    assign error_communication_timed_out = err_q;

endmodule

// File: tb/tb_ps2_command_tx.sv
// Bench for ps2_command_tx: PS/2 device model plus outcome and frame scoreboards.
// Timing is scaled to a 1 MHz clock so every timeout fits a short run.
module tb_ps2_command_tx;
    localparam int unsigned ClkHz         = 1_000_000;
    localparam int unsigned CyclesPerUs   = ClkHz / 1_000_000;
    localparam int unsigned InhibitCycles = 100 * CyclesPerUs;
    localparam int unsigned StartCycles   = 15_000 * CyclesPerUs;
    localparam int unsigned XferCycles    = 2_000 * CyclesPerUs;
    localparam int unsigned SyncLat       = 3;   // device edge to FSM reaction
    localparam int unsigned Half          = 20;  // device half clock period in cycles

`ifdef PS2_TX_ACK_CHECK_EN
    localparam logic [1:0] NoAckOutcome = 2'b01;
`else
    localparam logic [1:0] NoAckOutcome = 2'b10;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       send_command;
    logic [7:0] the_command;
    logic       busy, command_was_sent, error_communication_timed_out;
    wire        ps2_clk, ps2_dat;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    int unsigned cyc = 0;
    int unsigned last_outcome_cyc = 0;
    int unsigned t_fall1 = 0;
    logic [1:0]  lines_at_outcome = 2'b00;
    int          n_total = 0;
    int          n_bad = 0;
    logic [1:0]  outcome_q[$];  // {sent, error}
    logic [9:0]  frame_q[$];    // {stop, parity, data}

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    ps2_command_tx #(
        .CLK_HZ (ClkHz)
    ) dut (
        .clock                         (clock),
        .reset                         (reset),
        .the_command                   (the_command),
        .send_command                  (send_command),
        .ps2_clk                       (ps2_clk),
        .ps2_dat                       (ps2_dat),
        .busy                          (busy),
        .command_was_sent              (command_was_sent),
        .error_communication_timed_out (error_communication_timed_out)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && (command_was_sent || error_communication_timed_out)) begin
            last_outcome_cyc = cyc;
            lines_at_outcome = {ps2_clk, ps2_dat};
            if (outcome_q.size() == 0) begin
                check_eq("unexpected_outcome",
                         {30'd0, command_was_sent, error_communication_timed_out}, 32'd0);
            end else begin
                check_eq("outcome", {30'd0, command_was_sent, error_communication_timed_out},
                         {30'd0, outcome_q.pop_front()});
            end
        end
    end

    task automatic send(input logic [7:0] c, input logic [1:0] exp_outcome, input bit with_frame);
        @(negedge clock);
        the_command  = c;
        send_command = 1'b1;
        if (exp_outcome != 2'b00) outcome_q.push_back(exp_outcome);
        if (with_frame) frame_q.push_back({1'b1, ~^c, c});
        @(negedge clock);
        send_command = 1'b0;
        the_command  = ~c;
    endtask

    // Called on the first sample after acceptance; generates n_clocks device clocks.
    task automatic device(input int n_clocks, input bit ack, input bit check_frame);
        int         low = 0;
        logic [9:0] rx = '0;
        logic [9:0] exp;
        while (ps2_clk === 1'b0 && low < int'(4 * InhibitCycles)) begin
            low++;
            @(negedge clock);
        end
        check_eq("inhibit_len", 32'(low), InhibitCycles);
        check_eq("start_bit", {31'd0, ps2_dat}, 32'd0);
        check_eq("busy_in_xfer", {31'd0, busy}, 32'd1);
        for (int i = 1; i <= n_clocks; i++) begin
            repeat (Half / 2) @(negedge clock);
            if (i == 11 && ack) dev_dat_low = 1'b1;
            repeat (Half / 2) @(negedge clock);
            dev_clk_low = 1'b1;
            if (i == 1) t_fall1 = cyc;
            repeat (Half) @(negedge clock);
            if (i <= 10) rx[i-1] = ps2_dat;
            dev_clk_low = 1'b0;
        end
        repeat (Half) @(negedge clock);
        dev_dat_low = 1'b0;
        if (check_frame) begin
            if (frame_q.size() == 0) begin
                check_eq("frame_expected", 32'd0, 32'd1);
            end else begin
                exp = frame_q.pop_front();
                check_eq("data_byte", {24'd0, rx[7:0]}, {24'd0, exp[7:0]});
                check_eq("parity", {31'd0, rx[8]}, {31'd0, exp[8]});
                check_eq("stop", {31'd0, rx[9]}, {31'd0, exp[9]});
            end
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (outcome_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (outcome_q.size() != 0) begin
            check_eq("outcome_wait", 32'(outcome_q.size()), 32'd0);
            outcome_q.delete();
        end
    endtask

    initial begin
        int          n;
        int unsigned t0;
        int          spurious;
        reset        = 1'b1;
        send_command = 1'b0;
        the_command  = 8'h00;
        repeat (3) @(negedge clock);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_sent", {31'd0, command_was_sent}, 32'd0);
        check_eq("rst_err", {31'd0, error_communication_timed_out}, 32'd0);
        check_eq("rst_lines", {30'd0, ps2_clk, ps2_dat}, 32'd3);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Set-LEDs command, device acknowledges.
        send(8'hED, 2'b10, 1'b1);
        device(11, 1'b1, 1'b1);
        drain(200);
        @(negedge clock);
        check_eq("ed_busy_low", {31'd0, busy}, 32'd0);

        // Enable command with a request pulsed mid-transfer that must be dropped.
        send(8'hF4, 2'b10, 1'b1);
        fork
            device(11, 1'b1, 1'b1);
            begin
                repeat (InhibitCycles + 60) @(negedge clock);
                send_command = 1'b1;
                the_command  = 8'h00;
                @(negedge clock);
                send_command = 1'b0;
            end
        join
        drain(200);
        @(negedge clock);
        check_eq("f4_busy_low", {31'd0, busy}, 32'd0);
        spurious = 0;
        repeat (3 * InhibitCycles) begin
            @(negedge clock);
            if (ps2_clk !== 1'b1 || busy !== 1'b0) spurious++;
        end
        check_eq("no_second_xfer", 32'(spurious), 32'd0);

        // Reset command with a silent device: start timeout.
        send(8'hFF, 2'b01, 1'b0);
        n = 0;
        while (ps2_clk === 1'b0 && n < int'(4 * InhibitCycles)) begin
            @(negedge clock);
            n++;
        end
        t0 = cyc;
        check_eq("silent_start_bit", {31'd0, ps2_dat}, 32'd0);
        drain(int'(StartCycles) + 100);
        check_eq("start_timeout_lat", last_outcome_cyc - t0, StartCycles);
        check_eq("silent_lines", {30'd0, lines_at_outcome}, 32'd3);

        // Device stops clocking after bit3: transfer timeout.
        send(8'h3C, 2'b01, 1'b0);
        device(4, 1'b0, 1'b0);
        drain(int'(XferCycles) + 100);
        check_eq("xfer_timeout_lat", last_outcome_cyc - t_fall1, XferCycles + SyncLat);
        check_eq("xfer_lines", {30'd0, lines_at_outcome}, 32'd3);

        // Device never acknowledges.
        send(8'hA5, NoAckOutcome, 1'b1);
        device(11, 1'b0, 1'b1);
        drain(200);

        // Reset while bit5 (a 0) is on the bus.
        send(8'h5A, 2'b00, 1'b0);
        device(6, 1'b0, 1'b0);
        check_eq("bit5_driven", {31'd0, ps2_dat}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check_eq("rst_mid_lines", {30'd0, ps2_clk, ps2_dat}, 32'd3);
        check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        repeat (200) @(negedge clock);
        check_eq("post_rst_idle", {30'd0, busy, ps2_clk}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule
